// File: rtl/clock_alarm_ctrl_pkg.sv
// Shared types, limits and display helpers for the clock/alarm controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN_DISARMED = 2'b00,
    RUN_ARMED    = 2'b01,
    SET_TIME     = 2'b10,
    SET_ALARM    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int SECONDS_MAX = 59;

  // Active-low segments, bit6..0 = g..a; anything above 9 is blanked.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Returns {tens, units} for a value below 64 by repeated subtraction.
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/clock_alarm_ctrl_if.sv
// Board-side pin bundle of the clock controller plus debug visibility of its FSM.
// No valid/ready handshake: keys and switches are raw asynchronous levels, all outputs are registered levels.
interface clock_alarm_ctrl_if;
  logic                        key_0_n;
  logic                        key_1_n;
  logic                        key_2_n;
  logic [1:0]                  switches;
  logic [6:0]                  hex_hours_ms;
  logic [6:0]                  hex_hours_ls;
  logic [6:0]                  hex_minutes_ms;
  logic [6:0]                  hex_minutes_ls;
  logic                        buzzer;
  clock_ctrl_pkg::alarm_state_t alarm_state;
  clock_ctrl_pkg::mode_t        mode;

  modport master (
    output key_0_n, key_1_n, key_2_n, switches,
    input  hex_hours_ms, hex_hours_ls, hex_minutes_ms, hex_minutes_ls, buzzer,
    input  alarm_state, mode
  );

  modport slave (
    input  key_0_n, key_1_n, key_2_n, switches,
    output hex_hours_ms, hex_hours_ls, hex_minutes_ms, hex_minutes_ls, buzzer,
    output alarm_state, mode
  );
endinterface

// File: rtl/clock_alarm_ctrl_key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter, one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  // level only follows s2 after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/clock_alarm_ctrl.sv
// HH:MM:SS timekeeper with button setting, 7-segment display and alarm/snooze buzzer sequencer.
module clock_alarm_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BEEP_DIV        = 12500,
  parameter int RING_SECONDS    = 60,
  parameter int SNOOZE_SECONDS  = 300,
  parameter int ALARM_RST_H     = 7,
  parameter int ALARM_RST_M     = 0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  clock_alarm_ctrl_if.slave    pins
);
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW     = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int SC_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int SW     = $clog2(SC_MAX + 1);

  logic          k0_ev, k1_ev, k2_ev;
  logic [1:0]    sw_s1, sw_s2;
  mode_t         mode;
  logic [PW-1:0] presc;
  logic          tick;
  logic [4:0]    hours, alarm_h, nxt_hr, disp_h;
  logic [5:0]    minutes, seconds, alarm_m, nxt_min, nxt_sec, disp_m;
  logic          alarm_hit;
  alarm_state_t  state;
  logic [SW-1:0] sec_cnt;
  logic [BW-1:0] beep_cnt;
  logic          buzzer;
  logic [7:0]    hh_bcd, mm_bcd;
  logic [6:0]    hex_h_ms, hex_h_ls, hex_m_ms, hex_m_ls;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk(clk_clk), .rst_n(reset_reset_n), .key_n(pins.key_0_n), .press(k0_ev));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk(clk_clk), .rst_n(reset_reset_n), .key_n(pins.key_1_n), .press(k1_ev));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk(clk_clk), .rst_n(reset_reset_n), .key_n(pins.key_2_n), .press(k2_ev));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_s1 <= 2'b00;
      sw_s2 <= 2'b00;
    end else begin
      sw_s1 <= pins.switches;
      sw_s2 <= sw_s1;
    end
  end

  assign mode = mode_t'(sw_s2);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                                     presc <= '0;
    else if (mode == SET_TIME || presc == PW'(TICK_DIV - 1)) presc <= '0;
    else                                                    presc <= presc + PW'(1);
  end

  assign tick = (mode != SET_TIME) && (presc == PW'(TICK_DIV - 1));

  always_comb begin
    nxt_sec = seconds + 6'd1;
    nxt_min = minutes;
    nxt_hr  = hours;
    if (seconds == 6'(SECONDS_MAX)) begin
      nxt_sec = 6'd0;
      nxt_min = minutes + 6'd1;
      if (minutes == 6'(MINUTES_MAX)) begin
        nxt_min = 6'd0;
        nxt_hr  = (hours == 5'(HOURS_MAX)) ? 5'd0 : hours + 5'd1;
      end
    end
  end

  // Wall time advances only in the RUN modes; SET_ALARM leaves it frozen.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hours   <= 5'd0;
      minutes <= 6'd0;
      seconds <= 6'd0;
      alarm_h <= 5'(ALARM_RST_H);
      alarm_m <= 6'(ALARM_RST_M);
    end else begin
      if (mode == SET_TIME) begin
        seconds <= 6'd0;
        if (k0_ev) hours   <= (hours == 5'(HOURS_MAX)) ? 5'd0 : hours + 5'd1;
        if (k1_ev) minutes <= (minutes == 6'(MINUTES_MAX)) ? 6'd0 : minutes + 6'd1;
      end else if ((mode == RUN_DISARMED || mode == RUN_ARMED) && tick) begin
        seconds <= nxt_sec;
        minutes <= nxt_min;
        hours   <= nxt_hr;
      end
      if (mode == SET_ALARM) begin
        if (k0_ev) alarm_h <= (alarm_h == 5'(HOURS_MAX)) ? 5'd0 : alarm_h + 5'd1;
        if (k1_ev) alarm_m <= (alarm_m == 6'(MINUTES_MAX)) ? 6'd0 : alarm_m + 6'd1;
      end
    end
  end

  assign alarm_hit = (mode == RUN_ARMED) && tick && (nxt_sec == 6'd0) &&
                     (nxt_min == alarm_m) && (nxt_hr == alarm_h);

  // Leaving RUN_ARMED overrides every other transition, including a same-cycle snooze.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      sec_cnt  <= '0;
      beep_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (mode != RUN_ARMED) begin
      state    <= IDLE;
      sec_cnt  <= '0;
      beep_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_hit) begin
            state    <= RINGING;
            sec_cnt  <= '0;
            beep_cnt <= '0;
            buzzer   <= 1'b1;
          end
        end
        RINGING: begin
          if (k2_ev) begin
            state    <= SNOOZE;
            sec_cnt  <= '0;
            beep_cnt <= '0;
            buzzer   <= 1'b0;
          end else if (tick && sec_cnt == SW'(RING_SECONDS - 1)) begin
            state    <= IDLE;
            sec_cnt  <= '0;
            beep_cnt <= '0;
            buzzer   <= 1'b0;
          end else begin
            if (tick) sec_cnt <= sec_cnt + SW'(1);
            if (beep_cnt == BW'(BEEP_DIV - 1)) begin
              beep_cnt <= '0;
              buzzer   <= ~buzzer;
            end else begin
              beep_cnt <= beep_cnt + BW'(1);
            end
          end
        end
        SNOOZE: begin
          if (tick) begin
            if (sec_cnt == SW'(SNOOZE_SECONDS - 1)) begin
              state    <= RINGING;
              sec_cnt  <= '0;
              beep_cnt <= '0;
              buzzer   <= 1'b1;
            end else begin
              sec_cnt <= sec_cnt + SW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          buzzer <= 1'b0;
        end
      endcase
    end
  end

  assign disp_h = (mode == SET_ALARM) ? alarm_h : hours;
  assign disp_m = (mode == SET_ALARM) ? alarm_m : minutes;
  assign hh_bcd = bcd_split({1'b0, disp_h});
  assign mm_bcd = bcd_split(disp_m);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hex_h_ms <= 7'b1000000;
      hex_h_ls <= 7'b1000000;
      hex_m_ms <= 7'b1000000;
      hex_m_ls <= 7'b1000000;
    end else begin
      hex_h_ms <= seg7_decode(hh_bcd[7:4]);
      hex_h_ls <= seg7_decode(hh_bcd[3:0]);
      hex_m_ms <= seg7_decode(mm_bcd[7:4]);
      hex_m_ls <= seg7_decode(mm_bcd[3:0]);
    end
  end

  assign pins.hex_hours_ms   = hex_h_ms;
  assign pins.hex_hours_ls   = hex_h_ls;
  assign pins.hex_minutes_ms = hex_m_ms;
  assign pins.hex_minutes_ls = hex_m_ls;
  assign pins.buzzer         = buzzer;
  assign pins.alarm_state    = state;
  assign pins.mode           = mode;
endmodule
